sha256_round_pipe_stage: RTL
============================

// Module: sha256_round_pipe_stage
// PURPOSE
//  One SHA-256 compression round as an elastic pipeline stage. Consumes the expanded word W[t]
//  produced by the matching message-expander stage (the low word of its 256-bit window) with the
//  working state a..h, and emits the updated state one cycle later. Chains with one instance per
//  round t to form the double-SHA256 compression datapath.
//  Includes a 2-entry output/skid buffer for full throughput under backpressure.
// PARAMETERS
//  ROUND_IDX  17            round index t; documentation/assertion use only
//  K_CONST    32'hefbe4786  round constant K[t] (K[17] by default)
//  TAG_W      8             width of sideband tag (job/nonce id) carried alongside the state
// PORTS
//  CLK        in   1        clock, rising edge
//  RST        in   1        asynchronous reset, active-low
//  in_valid   in   1        state_in/w_in/tag_in valid
//  in_ready   out  1        stage can accept; driven directly from a flop
//  state_in   in   256      {a,b,c,d,e,f,g,h}, a in [255:224]
//  w_in       in   32       expanded message word W[t]
//  tag_in     in   TAG_W    sideband, passed through unchanged
//  out_valid  out  1        state_out/tag_out valid
//  out_ready  in   1        downstream accepts
//  state_out  out  256      updated {a',b',c',d',e',f',g',h'}
//  tag_out    out  TAG_W    sideband matching state_out
// BEHAVIOUR
//  - Round, all adds mod 2^32:
//    S1=ror(e,6)^ror(e,11)^ror(e,25); Ch=(e&f)^(~e&g); T1=h+S1+Ch+K_CONST+w_in
//    S0=ror(a,2)^ror(a,13)^ror(a,22); Maj=(a&b)^(a&c)^(b&c); T2=S0+Maj
//    result={T1+T2, a, b, c, d+T1, e, f, g}
//  - Round logic is combinational on the input side; result is captured at acceptance.
//  - Accept: in_valid & in_ready at a rising edge. Latency accept->out_valid = 1 cycle.
//  - Storage: main reg (drives outputs) + skid reg. in_ready = ~skid_valid (registered).
//  - Per edge, with acc=in_valid&in_ready and pop=out_valid&out_ready:
//    main empty or pop: main <= skid if skid_valid (skid frees) else input result if acc
//    (main_valid <= skid_valid | acc).
//    main full & ~pop & acc: skid <= input result, skid_valid <= 1.
//    Simultaneous pop & acc with skid full cannot occur (in_ready=0).
//  - Ordering strictly FIFO; no data dropped or duplicated; throughput 1/cycle while out_ready=1.
//  - out_ready=0 persistent: at most 2 transactions held, then in_ready=0.
//  - Outputs stable while out_valid & ~out_ready (AXI-style hold).
//  - Reset (any time, async assert): out_valid=0, skid_valid=0, in_ready=1, state_out=0,
//    tag_out=0; in-flight data discarded. Deassertion synchronised externally.
//  - X on data inputs while in_valid=0 must not propagate to outputs.
// STRUCTURE
//  - sha256_pkg: K[0:63] table, ror/S0/S1/s0/s1/Ch/Maj functions, state struct/width constants;
//    shared with the expander stages.
//  - Sub-module sha256_round_comb: pure combinational round (state_in, w_in, K) -> result;
//    this stage = sha256_round_comb + 2-entry elastic buffer.
// TESTING
//  - "abc" round 0, K_CONST=32'h428a2f98, state=H0 (6a09e667..5be0cd19), W=61626380 ->
//    state_out = 5d6aebcd 6a09e667 bb67ae85 3c6ef372 fa2a4622 510e527f 9b05688c 1f83d9ab, 1 cycle.
//  - Streaming 100 random vectors, out_ready=1 -> 1 result/cycle, in order, match C model.
//  - out_ready=0 with in_valid=1: 2 accepted, in_ready low cycle after 2nd; release -> both out
//    in order, in_ready high again next cycle; tags preserved.
//  - Random in_valid/out_ready (50%), 10k items -> scoreboard exact match, no loss/dup.
//  - Assert RST mid-stream with both entries full -> out_valid=0, in_ready=1, outputs zero
//    immediately; first post-reset item emerges correctly.
//  - Wrap: all-ones state, W=ffffffff -> sums wrap mod 2^32, match model.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared SHA-256 definitions for the round and message-expander stages:
//   word/state widths, the packed working-state struct {a..h} with a at the MSBs,
//   the 64-entry round-constant table K[0:63], and the bitwise helper functions
//   (rotate, big/small sigma, Ch, Maj).
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int STATE_W = 8 * WORD_W;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } state_t;

    localparam word_t K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Rotate right; callers only use amounts in 1..31.
    function automatic word_t ror(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// sha256_round_comb
//   Purely combinational SHA-256 compression round. All additions wrap mod 2^32.
//   Ports:
//     state_in  in  256  {a,b,c,d,e,f,g,h}, a in [255:224]
//     w_in      in  32   expanded message word W[t]
//     k_in      in  32   round constant K[t]
//     result    out 256  {T1+T2, a, b, c, d+T1, e, f, g}
module sha256_round_comb
    import sha256_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    input  logic [WORD_W-1:0]  w_in,
    input  logic [WORD_W-1:0]  k_in,
    output logic [STATE_W-1:0] result
);

    state_t cur;
    state_t nxt;
    word_t  t1;
    word_t  t2;

    always_comb begin
        cur   = state_t'(state_in);
        t1    = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k_in + w_in;
        t2    = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
        nxt.a = t1 + t2;
        nxt.b = cur.a;
        nxt.c = cur.b;
        nxt.d = cur.c;
        nxt.e = cur.d + t1;
        nxt.f = cur.e;
        nxt.g = cur.f;
        nxt.h = cur.g;
        result = nxt;
    end

endmodule

// File: rtl/sha256_round_pipe_stage.sv
// sha256_round_pipe_stage
//   One SHA-256 round as an elastic valid/ready pipeline stage. The round is
//   evaluated combinationally from the input side and captured on acceptance;
//   a main register drives the outputs and a skid register absorbs one extra
//   transaction so the stage sustains one item per cycle under backpressure.
//   Ports:
//     CLK        in   1      clock, rising edge
//     RST        in   1      asynchronous reset, active-low
//     in_valid   in   1      state_in/w_in/tag_in valid
//     in_ready   out  1      stage can accept (registered, = ~skid occupied)
//     state_in   in   256    {a..h}, a in [255:224]
//     w_in       in   32     expanded message word W[t]
//     tag_in     in   TAG_W  sideband passed through unchanged
//     out_valid  out  1      state_out/tag_out valid
//     out_ready  in   1      downstream accepts
//     state_out  out  256    updated state
//     tag_out    out  TAG_W  sideband matching state_out
module sha256_round_pipe_stage
    import sha256_pkg::*;
#(
    parameter int unsigned ROUND_IDX = 17,
    parameter logic [31:0] K_CONST   = 32'hefbe4786,
    parameter int unsigned TAG_W     = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic [WORD_W-1:0]  w_in,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic [TAG_W-1:0]   tag_out
);

    localparam logic [5:0] ROUND_SLOT = 6'(ROUND_IDX % 64);

    logic [STATE_W-1:0] result_p0;
    logic               acc_p0;
    logic               pop_p0;
    logic               load_main_p0;

    logic [STATE_W-1:0] main_state_p1;
    logic [TAG_W-1:0]   main_tag_p1;
    logic               vld_p1;
    logic [STATE_W-1:0] skid_state_p1;
    logic [TAG_W-1:0]   skid_tag_p1;
    logic               skid_vld_p1;
    logic               ready_p1;

    // ---- p0: combinational round on the input side ----
    sha256_round_comb u_round (
        .state_in (state_in),
        .w_in     (w_in),
        .k_in     (K_CONST),
        .result   (result_p0)
    );

    always_comb begin
        acc_p0       = in_valid & ready_p1;
        pop_p0       = vld_p1 & out_ready;
        // Main register may be (re)loaded when it is empty or being drained.
        load_main_p0 = ~vld_p1 | pop_p0;
    end

    // ---- p1: main (output) register, skid control, registered ready ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_p1        <= 1'b0;
            skid_vld_p1   <= 1'b0;
            ready_p1      <= 1'b1;
            main_state_p1 <= '0;
            main_tag_p1   <= '0;
        end else begin
            if (load_main_p0) begin
                if (skid_vld_p1) begin
                    // Skid holds the older item; it moves up first. No accept
                    // can coincide because ready is low while skid is full.
                    main_state_p1 <= skid_state_p1;
                    main_tag_p1   <= skid_tag_p1;
                    vld_p1        <= 1'b1;
                    skid_vld_p1   <= 1'b0;
                    ready_p1      <= 1'b1;
                end else begin
                    vld_p1 <= acc_p0;
                    if (acc_p0) begin
                        main_state_p1 <= result_p0;
                        main_tag_p1   <= tag_in;
                    end
                end
            end else if (acc_p0) begin
                skid_vld_p1 <= 1'b1;
                ready_p1    <= 1'b0;
            end
        end
    end

    // Skid payload is only observed while skid_vld_p1 is set, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (!load_main_p0 && acc_p0) begin
            skid_state_p1 <= result_p0;
            skid_tag_p1   <= tag_in;
        end
    end

    assign in_ready  = ready_p1;
    assign out_valid = vld_p1;
    assign state_out = main_state_p1;
    assign tag_out   = main_tag_p1;

    a_ready_mirrors_skid: assert property (@(posedge CLK) disable iff (!RST)
        ready_p1 == ~skid_vld_p1);
    a_skid_implies_main: assert property (@(posedge CLK) disable iff (!RST)
        skid_vld_p1 |-> vld_p1);
    a_k_matches_round: assert property (@(posedge CLK) disable iff (!RST)
        K_CONST == K_TABLE[ROUND_SLOT]);

endmodule
